// File: rtl/reduce_collector_if.sv
// Partitioner-to-reducer request bus: request/ack handshake plus the
// per-partitioner value word and key index lanes.
interface reduce_collector_if #(
  parameter int NUM_OF_PARTITIONERS = 4,
  parameter int PRECISION           = 16
);
  logic [NUM_OF_PARTITIONERS-1:0]           i_request;
  logic [NUM_OF_PARTITIONERS-1:0]           o_acknowledged;
  logic [NUM_OF_PARTITIONERS*PRECISION-1:0] i_value_data;
  logic [NUM_OF_PARTITIONERS*16-1:0]        i_mem_index;

  modport master (
    output i_request,
    output i_value_data,
    output i_mem_index,
    input  o_acknowledged
  );

  modport slave (
    input  i_request,
    input  i_value_data,
    input  i_mem_index,
    output o_acknowledged
  );
endinterface

// File: rtl/reduce_collector.sv
// Reducer collector: round-robin grant, serial word capture, per-key bank.
// Ports: clock, reset_n (async low), bus (request/ack/value/index lanes),
//   i_clear, i_rd_en/i_rd_addr -> o_rd_valid/o_rd_sum/o_rd_count,
//   o_busy, o_index_error (sticky). Macro REDUCE_SATURATE_EN clamps sums/count.
module reduce_collector #(
  parameter int NUM_OF_PARTITIONERS = 4,
  parameter int PRECISION           = 16,
  parameter int DIMENSION           = 2,
  parameter int NUM_OF_KEYS         = 16,
  parameter int ACC_WIDTH           = 32,
  parameter int COUNT_WIDTH         = 16,
  localparam int KW = (NUM_OF_KEYS > 1) ? $clog2(NUM_OF_KEYS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  reduce_collector_if.slave              bus,
  input  logic                           i_clear,
  input  logic                           i_rd_en,
  input  logic [KW-1:0]                  i_rd_addr,
  output logic                           o_rd_valid,
  output logic [DIMENSION*ACC_WIDTH-1:0] o_rd_sum,
  output logic [COUNT_WIDTH-1:0]         o_rd_count,
  output logic                           o_busy,
  output logic                           o_index_error
);

  localparam int N  = NUM_OF_PARTITIONERS;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int SW = DIMENSION * ACC_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ACK, WAIT, COLLECT, WRITE
  } state_t;

  state_t              state_q;
  logic [GW-1:0]       rr_q;
  logic [GW-1:0]       gnt_q;
  logic [N-1:0]        ack_q;
  logic                busy_q;
  logic                err_q;
  logic                drop_q;
  logic [KW-1:0]       key_q;
  logic [DW-1:0]       dcnt_q;
  logic [SW-1:0]       work_sum_q;
  logic [COUNT_WIDTH-1:0] work_cnt_q;

  logic [SW-1:0]          bank_sum_q [NUM_OF_KEYS];
  logic [COUNT_WIDTH-1:0] bank_cnt_q [NUM_OF_KEYS];

  logic                   rd_valid_q;
  logic [SW-1:0]          rd_sum_q;
  logic [COUNT_WIDTH-1:0] rd_cnt_q;

  logic                   found_d;
  logic [GW-1:0]          gnt_d;
  logic [15:0]            idx_w;
  logic [PRECISION-1:0]   word_w;
  logic                   idx_ok_w;

  assign bus.o_acknowledged = ack_q;
  assign o_busy        = busy_q;
  assign o_index_error = err_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_sum      = rd_sum_q;
  assign o_rd_count    = rd_cnt_q;

  assign idx_w    = bus.i_mem_index[gnt_q*16 +: 16];
  assign word_w   = bus.i_value_data[gnt_q*PRECISION +: PRECISION];
  assign idx_ok_w = (idx_w < 16'(NUM_OF_KEYS));

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    found_d = 1'b0;
    gnt_d   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found_d && bus.i_request[(int'(rr_q) + k) % N]) begin
        found_d = 1'b1;
        gnt_d   = GW'((int'(rr_q) + k) % N);
      end
    end
  end

  function automatic logic [ACC_WIDTH-1:0] add_acc(
    input logic [ACC_WIDTH-1:0] a,
    input logic [PRECISION-1:0] w
  );
    logic [ACC_WIDTH-1:0] e;
    logic [ACC_WIDTH-1:0] s;
    e = ACC_WIDTH'(signed'(w));
    s = a + e;
`ifdef REDUCE_SATURATE_EN
    if (a[ACC_WIDTH-1] == e[ACC_WIDTH-1] &&
        s[ACC_WIDTH-1] != a[ACC_WIDTH-1]) begin
      s = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] inc_cnt(
    input logic [COUNT_WIDTH-1:0] c
  );
`ifdef REDUCE_SATURATE_EN
    return (&c) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  // WRITE may arbitrate directly so back-to-back transactions
  // issue one grant every DIMENSION+3 cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      key_q      <= '0;
      dcnt_q     <= '0;
      work_sum_q <= '0;
      work_cnt_q <= '0;
      for (int k = 0; k < NUM_OF_KEYS; k++) begin
        bank_sum_q[k] <= '0;
        bank_cnt_q[k] <= '0;
      end
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (i_clear) begin
            for (int k = 0; k < NUM_OF_KEYS; k++) begin
              bank_sum_q[k] <= '0;
              bank_cnt_q[k] <= '0;
            end
          end else if (found_d) begin
            state_q <= ACK;
            gnt_q   <= gnt_d;
            ack_q   <= N'(1) << gnt_d;
            busy_q  <= 1'b1;
          end
        end
        ACK: begin
          rr_q    <= (gnt_q == GW'(N-1)) ? '0 : gnt_q + 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          key_q  <= idx_w[KW-1:0];
          dcnt_q <= '0;
          if (idx_ok_w) begin
            work_sum_q <= bank_sum_q[idx_w[KW-1:0]];
            work_cnt_q <= bank_cnt_q[idx_w[KW-1:0]];
            drop_q     <= 1'b0;
          end else begin
            err_q  <= 1'b1;
            drop_q <= 1'b1;
          end
          state_q <= COLLECT;
        end
        COLLECT: begin
          work_sum_q[dcnt_q*ACC_WIDTH +: ACC_WIDTH] <=
            add_acc(work_sum_q[dcnt_q*ACC_WIDTH +: ACC_WIDTH], word_w);
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == DW'(DIMENSION-1)) state_q <= WRITE;
        end
        WRITE: begin
          if (!drop_q) begin
            bank_sum_q[key_q] <= work_sum_q;
            bank_cnt_q[key_q] <= inc_cnt(work_cnt_q);
          end
          if (!i_clear && found_d) begin
            state_q <= ACK;
            gnt_q   <= gnt_d;
            ack_q   <= N'(1) << gnt_d;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Same-edge sampling makes a read of the key being written
  // return the pre-write value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_sum_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        rd_sum_q <= bank_sum_q[i_rd_addr];
        rd_cnt_q <= bank_cnt_q[i_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_reduce_collector.sv
// Directed bench for reduce_collector: default instance plus an
// ACC_WIDTH=16 instance sharing the same stimulus for overflow cases.
module tb_reduce_collector;
  localparam int N = 4;
  localparam int P = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reduce_collector_if #(.NUM_OF_PARTITIONERS(N), .PRECISION(P)) bus ();
  reduce_collector_if #(.NUM_OF_PARTITIONERS(N), .PRECISION(P)) b16 ();

  assign b16.i_request    = bus.i_request;
  assign b16.i_value_data = bus.i_value_data;
  assign b16.i_mem_index  = bus.i_mem_index;

  logic        clr, rd_en;
  logic [3:0]  rd_addr;
  logic        v32, busy32, err32;
  logic [63:0] s32;
  logic [15:0] c32;
  logic        v16, busy16, err16;
  logic [31:0] s16;
  logic [15:0] c16;

  reduce_collector u_dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .i_clear(clr), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_valid(v32), .o_rd_sum(s32), .o_rd_count(c32),
    .o_busy(busy32), .o_index_error(err32)
  );

  reduce_collector #(.ACC_WIDTH(16)) u_d16 (
    .clock(clock), .reset_n(reset_n), .bus(b16),
    .i_clear(clr), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_valid(v16), .o_rd_sum(s16), .o_rd_count(c16),
    .o_busy(busy16), .o_index_error(err16)
  );

  int total = 0;
  int bad   = 0;
  int ack_pulses = 0;
  int multi = 0;

  always @(negedge clock) begin
    ack_pulses += $countones(bus.o_acknowledged);
    if ($countones(bus.o_acknowledged) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_ack(input int p);
    int ok;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      tick();
      if (bus.o_acknowledged[p]) ok = 1;
    end
    bus.i_request[p] = 1'b0;
    chk("ack_seen", 64'(ok), 64'd1);
  endtask

  task automatic xfer(input int p, input logic [15:0] idx,
                      input logic [15:0] w0, input logic [15:0] w1);
    bus.i_request[p] = 1'b1;
    bus.i_mem_index[p*16 +: 16] = idx;
    wait_ack(p);
    tick();
    bus.i_value_data[p*P +: P] = w0;
    tick();
    tick();
    bus.i_value_data[p*P +: P] = w1;
    tick();
    tick();
  endtask

  logic [15:0] exp16;
  int g[5];
  int gc[5];
  int ng;
  int a0;

  initial begin
    bus.i_request    = '0;
    bus.i_value_data = '0;
    bus.i_mem_index  = '0;
    clr = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
`ifdef REDUCE_SATURATE_EN
    exp16 = 16'h7FFF;
`else
    exp16 = 16'h8010;
`endif

    #12;
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_ack", 64'(bus.o_acknowledged), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy32), 64'd0);
    chk("idle_err", 64'(err32), 64'd0);
    chk("idle_valid", 64'(v32), 64'd0);
    rd(4'd3);
    chk("rd3_valid", 64'(v32), 64'd1);
    chk("rd3_sum", s32, 64'd0);
    chk("rd3_cnt", 64'(c32), 64'd0);

    a0 = ack_pulses;
    xfer(1, 16'd5, 16'h0010, 16'hFFFF);
    chk("t2_ack_once", 64'(ack_pulses - a0), 64'd1);
    rd(4'd5);
    chk("t2_valid", 64'(v32), 64'd1);
    chk("t2_sum", s32, {32'hFFFF_FFFF, 32'h0000_0010});
    chk("t2_cnt", 64'(c32), 64'd1);
    tick();
    chk("t2_valid_drop", 64'(v32), 64'd0);
    chk("t2_sum_hold", s32, {32'hFFFF_FFFF, 32'h0000_0010});

    do_reset();
    bus.i_mem_index  = {4{16'd8}};
    bus.i_value_data = {4{16'h0001}};
    bus.i_request    = 4'hF;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      tick();
      for (int j = 0; j < N; j++) begin
        if (bus.o_acknowledged[j] && ng < 5) begin
          g[ng]  = j;
          gc[ng] = c;
          ng++;
        end
      end
      if (ng == 5) bus.i_request = '0;
    end
    bus.i_request = '0;
    chk("t3_grants", 64'(ng), 64'd5);
    for (int k = 0; k < 5; k++) chk("t3_order", 64'(g[k]), 64'(k % 4));
    for (int k = 1; k < 5; k++) chk("t3_gap", 64'(gc[k] - gc[k-1]), 64'd5);
    chk("t3_multi", 64'(multi), 64'd0);
    repeat (7) tick();
    bus.i_value_data = '0;
    rd(4'd8);
    chk("t3_sum", s32, {32'd5, 32'd5});
    chk("t3_cnt", 64'(c32), 64'd5);

    xfer(0, 16'd20, 16'h0001, 16'h0001);
    chk("t4_err", 64'(err32), 64'd1);
    chk("t4_busy", 64'(busy32), 64'd0);
    rd(4'd4);
    chk("t4_cnt4", 64'(c32), 64'd0);
    rd(4'd8);
    chk("t4_cnt8", 64'(c32), 64'd5);
    chk("t4_sum8", s32, {32'd5, 32'd5});

    xfer(2, 16'd2, 16'h7FF0, 16'h0000);
    xfer(2, 16'd2, 16'h0020, 16'h0000);
    rd(4'd2);
    chk("t5_sum16", 64'(s16[15:0]), 64'(exp16));
    chk("t5_sum32", s32, {32'd0, 32'h0000_8010});
    chk("t5_cnt16", 64'(c16), 64'd2);

    bus.i_request[3] = 1'b1;
    bus.i_mem_index[3*16 +: 16] = 16'd8;
    wait_ack(3);
    tick();
    bus.i_value_data[3*P +: P] = 16'd3;
    tick();
    clr = 1'b1;
    tick();
    chk("t6_busy_clr", 64'(busy32), 64'd1);
    tick();
    tick();
    chk("t6_idle", 64'(busy32), 64'd0);
    rd(4'd8);
    chk("t6_pre_clr_cnt", 64'(c32), 64'd6);
    chk("t6_pre_clr_sum", s32, {32'd8, 32'd8});
    clr = 1'b0;
    bus.i_value_data = '0;
    rd(4'd8);
    chk("t6_clr_cnt", 64'(c32), 64'd0);
    chk("t6_clr_sum", s32, 64'd0);

    rd_en = 1'b1;
    rd_addr = 4'd8;
    bus.i_request[0] = 1'b1;
    bus.i_mem_index[15:0] = 16'd1;
    wait_ack(0);
    tick();
    tick();
    chk("t6_busy_pre", 64'(busy32), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy32), 64'd0);
    chk("t6_rst_err", 64'(err32), 64'd0);
    chk("t6_rst_valid", 64'(v32), 64'd0);
    chk("t6_rst_ack", 64'(bus.o_acknowledged), 64'd0);
    rd_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
